// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel gradient pipeline.
// Holds the magnitude mode encoding, the gradient width derivation and
// the saturation test used by the output stage.
package sobel_pkg;

   // Magnitude selection; 2'b11 is treated the same as MODE_BOTH.
   typedef enum logic [1:0] {
      MODE_VERT = 2'b00,
      MODE_HORZ = 2'b01,
      MODE_BOTH = 2'b10
   } mode_t;

   // Signed gradient width: a 1-2-1 sum of pixel differences spans
   // +/-4*(2^pix_w-1), which needs pix_w+3 bits including sign.
   function automatic int grad_width(input int pix_w);
      return pix_w + 32'sd3;
   endfunction

   // True when an unsigned magnitude exceeds the largest pixel value.
   function automatic logic sat_over(input logic [31:0] raw, input int pix_w);
      logic [31:0] max_v;
      max_v = (32'd1 << pix_w) - 32'd1;
      return (raw > max_v);
   endfunction

endpackage

// File: rtl/sobel_kernel3.sv
// Combinational 1-2-1 weighted sum of three signed differences.
// Used once for the vertical and once for the horizontal gradient.
module sobel_kernel3 #(
   parameter int W = 11
) (
   input  logic signed [W-1:0] d0,
   input  logic signed [W-1:0] d1,
   input  logic signed [W-1:0] d2,
   output logic signed [W-1:0] sum
);

   // Centre difference carries double weight; range fits W by construction.
   always_comb begin
      sum = d0 + (d1 <<< 1) + d2;
   end

endmodule

// File: rtl/sobel_gradient_pipe.sv
// Three-stage Sobel gradient pipeline producing gx, gy and a saturated
// mode-selected magnitude behind a valid/ready handshake. The whole pipe
// stalls together when the output is held; bubbles are not collapsed.
// Optional threshold flag enabled by defining SOBEL_THRESH_EN, which adds
// the thresh input and the is_edge output (edge is a reserved word).
module sobel_gradient_pipe
   import sobel_pkg::*;
#(
   parameter int PIX_W = 8
) (
   input  logic                               clk,
   input  logic                               n_rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [9*PIX_W-1:0]                 window,
   input  logic [1:0]                         mode,
`ifdef SOBEL_THRESH_EN
   input  logic [PIX_W-1:0]                   thresh,
   output logic                               is_edge,
`endif
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic signed [grad_width(PIX_W)-1:0] gx,
   output logic signed [grad_width(PIX_W)-1:0] gy,
   output logic [PIX_W-1:0]                   mag
);

   localparam int GRAD_W = grad_width(PIX_W);
   localparam int MAG_W  = grad_width(PIX_W);

   // Zero-extend a pixel into the signed gradient domain.
   function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
   endfunction

   logic                     advance_s;
   logic [PIX_W-1:0]         pix_s [9];
   logic signed [GRAD_W-1:0] gy_t0_s, gy_t1_s, gy_t2_s;
   logic signed [GRAD_W-1:0] gx_u0_s, gx_u1_s, gx_u2_s;

   // Stage 1 state
   logic                     s1_valid_r;
   logic signed [GRAD_W-1:0] s1_t0_r, s1_t1_r, s1_t2_r;
   logic signed [GRAD_W-1:0] s1_u0_r, s1_u1_r, s1_u2_r;
   logic [1:0]               s1_mode_r;

   // Stage 2 state
   logic                     s2_valid_r;
   logic signed [GRAD_W-1:0] s2_gx_r, s2_gy_r;
   logic [1:0]               s2_mode_r;
   logic signed [GRAD_W-1:0] sum_gx_s, sum_gy_s;

   // Stage 3 combinational
   logic [MAG_W-1:0]         abs_gx_s, abs_gy_s, mag_raw_s;
   logic [PIX_W-1:0]         mag_next_s;

`ifdef SOBEL_THRESH_EN
   logic [PIX_W-1:0]         s1_thresh_r;
   logic [PIX_W-1:0]         s2_thresh_r;
`endif

   // Global advance: the pipe moves unless a held result blocks the output.
   always_comb begin
      advance_s = !out_valid || out_ready;
      in_ready  = advance_s;
   end

   // Split the window into pixels and form the six signed differences.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         pix_s[i] = window[i*PIX_W +: PIX_W];
      end
      gy_t0_s = ext(pix_s[0]) - ext(pix_s[6]);
      gy_t1_s = ext(pix_s[1]) - ext(pix_s[7]);
      gy_t2_s = ext(pix_s[2]) - ext(pix_s[8]);
      gx_u0_s = ext(pix_s[2]) - ext(pix_s[0]);
      gx_u1_s = ext(pix_s[5]) - ext(pix_s[3]);
      gx_u2_s = ext(pix_s[8]) - ext(pix_s[6]);
   end

   // Stage 1: capture differences and sideband on an accepted window.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         s1_valid_r  <= 1'b0;
         s1_t0_r     <= '0;
         s1_t1_r     <= '0;
         s1_t2_r     <= '0;
         s1_u0_r     <= '0;
         s1_u1_r     <= '0;
         s1_u2_r     <= '0;
         s1_mode_r   <= 2'b00;
`ifdef SOBEL_THRESH_EN
         s1_thresh_r <= '0;
`endif
      end else if (advance_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_t0_r     <= gy_t0_s;
            s1_t1_r     <= gy_t1_s;
            s1_t2_r     <= gy_t2_s;
            s1_u0_r     <= gx_u0_s;
            s1_u1_r     <= gx_u1_s;
            s1_u2_r     <= gx_u2_s;
            s1_mode_r   <= mode;
`ifdef SOBEL_THRESH_EN
            s1_thresh_r <= thresh;
`endif
         end
      end
   end

   sobel_kernel3 #(.W(GRAD_W)) u_kernel_gy (
      .d0  (s1_t0_r),
      .d1  (s1_t1_r),
      .d2  (s1_t2_r),
      .sum (sum_gy_s)
   );

   sobel_kernel3 #(.W(GRAD_W)) u_kernel_gx (
      .d0  (s1_u0_r),
      .d1  (s1_u1_r),
      .d2  (s1_u2_r),
      .sum (sum_gx_s)
   );

   // Stage 2: register the weighted gradient sums.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         s2_valid_r  <= 1'b0;
         s2_gx_r     <= '0;
         s2_gy_r     <= '0;
         s2_mode_r   <= 2'b00;
`ifdef SOBEL_THRESH_EN
         s2_thresh_r <= '0;
`endif
      end else if (advance_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_gx_r     <= sum_gx_s;
            s2_gy_r     <= sum_gy_s;
            s2_mode_r   <= s1_mode_r;
`ifdef SOBEL_THRESH_EN
            s2_thresh_r <= s1_thresh_r;
`endif
         end
      end
   end

   // Absolute values, mode selection and saturation to the pixel range.
   always_comb begin
      if (s2_gx_r[GRAD_W-1]) begin
         abs_gx_s = MAG_W'($unsigned(-s2_gx_r));
      end else begin
         abs_gx_s = MAG_W'($unsigned(s2_gx_r));
      end
      if (s2_gy_r[GRAD_W-1]) begin
         abs_gy_s = MAG_W'($unsigned(-s2_gy_r));
      end else begin
         abs_gy_s = MAG_W'($unsigned(s2_gy_r));
      end
      case (s2_mode_r)
         MODE_VERT: mag_raw_s = abs_gy_s;
         MODE_HORZ: mag_raw_s = abs_gx_s;
         default:   mag_raw_s = abs_gx_s + abs_gy_s;
      endcase
      if (sat_over(32'(mag_raw_s), PIX_W)) begin
         mag_next_s = {PIX_W{1'b1}};
      end else begin
         mag_next_s = mag_raw_s[PIX_W-1:0];
      end
   end

   // Stage 3: registered outputs, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         out_valid <= 1'b0;
         gx        <= '0;
         gy        <= '0;
         mag       <= '0;
`ifdef SOBEL_THRESH_EN
         is_edge   <= 1'b0;
`endif
      end else if (advance_s) begin
         out_valid <= s2_valid_r;
         if (s2_valid_r) begin
            gx      <= s2_gx_r;
            gy      <= s2_gy_r;
            mag     <= mag_next_s;
`ifdef SOBEL_THRESH_EN
            is_edge <= (mag_next_s >= s2_thresh_r);
`endif
         end
      end
   end

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Directed self-checking bench for sobel_gradient_pipe (PIX_W = 8).
// Threshold checks are compiled in when SOBEL_THRESH_EN is defined.
module tb_sobel_gradient_pipe;

   localparam int PIX_W  = 8;
   localparam int GRAD_W = PIX_W + 3;

   logic                     clk = 1'b0;
   logic                     n_rst;
   logic                     in_valid;
   logic                     in_ready;
   logic [9*PIX_W-1:0]       window;
   logic [1:0]               mode;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [GRAD_W-1:0] gx;
   logic signed [GRAD_W-1:0] gy;
   logic [PIX_W-1:0]         mag;
`ifdef SOBEL_THRESH_EN
   logic [PIX_W-1:0]         thresh;
   logic                     is_edge;
`endif

   int total = 0;
   int bad   = 0;

   sobel_gradient_pipe #(.PIX_W(PIX_W)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .window    (window),
      .mode      (mode),
`ifdef SOBEL_THRESH_EN
      .thresh    (thresh),
      .is_edge   (is_edge),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .gx        (gx),
      .gy        (gy),
      .mag       (mag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [71:0] mkw(input logic [7:0] p0, p1, p2, p3, p4,
                                       p5, p6, p7, p8);
      return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
   endfunction

   // One isolated window: checks 3-cycle latency and a one-cycle valid pulse.
   task automatic run_one(input string tag, input logic [71:0] win,
                          input logic [1:0] md, input int egx, input int egy,
                          input int emag);
      window    = win;
      mode      = md;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk({tag, "_early"}, out_valid, 0);
      step();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_gx"}, gx, egx);
      chk({tag, "_gy"}, gy, egy);
      chk({tag, "_mag"}, mag, emag);
      step();
      chk({tag, "_pulse"}, out_valid, 0);
   endtask

`ifdef SOBEL_THRESH_EN
   task automatic run_thr(input string tag, input logic [71:0] win,
                          input int emag, input int eedge);
      window    = win;
      mode      = 2'b00;
      thresh    = 8'd100;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      thresh   = 8'd0;
      step();
      step();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_mag"}, mag, emag);
      chk({tag, "_edge"}, is_edge, eedge);
   endtask
`endif

   initial begin
      int sent;
      int got;
      int exp_v;
      logic [71:0] top_row;
      logic [71:0] right_col;

      n_rst     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mode      = 2'b00;
      window    = '0;
`ifdef SOBEL_THRESH_EN
      thresh    = 8'd0;
`endif
      top_row   = mkw(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      right_col = mkw(8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200);

      // Reset state
      step();
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_gx", gx, 0);
      chk("rst_gy", gy, 0);
      chk("rst_mag", mag, 0);
      chk("rst_in_ready", in_ready, 1);
      n_rst = 1'b1;
      step();

      // Directed windows
      run_one("top_vert", top_row, 2'b00, 0, 1020, 255);
      run_one("rcol_horz", right_col, 2'b01, 800, 0, 255);
      run_one("rcol_vert", right_col, 2'b00, 800, 0, 0);
      run_one("small_both", mkw(8'd10, 8'd0, 8'd14, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0),
              2'b10, 4, 24, 28);
      run_one("small_m11", mkw(8'd10, 8'd0, 8'd14, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0),
              2'b11, 4, 24, 28);
      run_one("neg_vert", mkw(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0),
              2'b00, -50, -50, 50);
      run_one("neg_horz", mkw(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0),
              2'b01, -50, -50, 50);
      run_one("neg_both", mkw(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0),
              2'b10, -50, -50, 100);

      // Stream of 6 windows with a 4-cycle output stall; window k has P0=20*(k+1)
      sent = 0;
      got  = 0;
      mode = 2'b00;
      for (int c = 0; c < 40; c++) begin
         in_valid  = (sent < 6);
         window    = mkw(8'(20 * (sent + 1)), 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
         out_ready = !(c >= 4 && c < 8);
         #1;
         if (out_valid) begin
            if (got < 6) begin
               exp_v = 20 * (got + 1);
               chk("strm_mag", mag, exp_v);
               chk("strm_gy", gy, exp_v);
               chk("strm_gx", gx, -exp_v);
            end else begin
               chk("strm_extra", out_valid, 0);
            end
            if (!out_ready) chk("strm_in_ready_stall", in_ready, 0);
            if (out_ready) got++;
         end
         if (in_valid && in_ready) sent++;
         step();
      end
      chk("strm_sent", sent, 6);
      chk("strm_got", got, 6);

      // Reset with three windows in flight
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         window = mkw(8'd30, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
         step();
      end
      in_valid = 1'b0;
      n_rst    = 1'b0;
      step();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_gx", gx, 0);
      chk("mid_rst_gy", gy, 0);
      chk("mid_rst_mag", mag, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      n_rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("post_rst_no_stale", out_valid, 0);
      end

`ifdef SOBEL_THRESH_EN
      run_thr("thr_99", mkw(8'd99, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 99, 0);
      run_thr("thr_100", mkw(8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 100, 1);
      run_thr("thr_255", top_row, 255, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sobel_gradient_pipe.md
Name: sobel_gradient_pipe

Overview:
Parametrised successor to the single-direction vertical Sobel stage. Computes both the vertical gradient gy and the horizontal gradient gx of a 3x3 window in a registered 3-stage pipeline. Forms a mode-selected, saturated magnitude with a valid/ready handshake on both sides. Sits between the line-buffer/window generator and the output pixel writer.

Parameters:
PIX_W, 8, pixel width in bits (unsigned)
GRAD_W, PIX_W+3, signed width of gx/gy; derived localparam, not overridable
MAG_W, PIX_W+3, unsigned width of |gx|+|gy| before saturation; derived localparam

Ports:
clk  in  1  rising-edge clock
n_rst  in  1  reset, synchronous, active-low
in_valid  in  1  window valid
in_ready  out  1  pipeline can accept a window this cycle
window  in  9*PIX_W  P0..P8, P0 at LSBs, row-major (P0-P2 top row, P6-P8 bottom row)
mode  in  2  00 vertical |gy|, 01 horizontal |gx|, 10/11 combined |gx|+|gy|
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
gx  out  GRAD_W  signed horizontal gradient
gy  out  GRAD_W  signed vertical gradient
mag  out  PIX_W  saturated magnitude per mode
edge  out  1  threshold flag; present only with SOBEL_THRESH_EN

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (n_rst). All flops clear when n_rst=0 at a rising edge.
- Reset values: out_valid=0, gx=0, gy=0, mag=0, edge=0, all stage valids=0. in_ready follows its equation, so it reads 1 after reset.
- Reset mid-operation discards all in-flight windows; no partial result is ever emitted.
- Stall rule: advance = !out_valid || out_ready; in_ready = advance.
  - Global stall: all three stages hold when advance=0.
  - No bubble collapsing.
- Input transfer occurs on in_valid && in_ready. Mode is sampled with the window and carried down the pipeline.
- Stage 1 registers:
  - gy terms: P0-P6, P1-P7, P2-P8.
  - gx terms: P2-P0, P5-P3, P8-P6.
  - Each term is sign-extended to GRAD_W.
- Stage 2:
  - gy = t0 + (t1<<1) + t2.
  - gx = u0 + (u1<<1) + u2.
  - Range is ±4*(2^PIX_W-1), so there is no overflow in GRAD_W.
- Stage 3:
  - Absolute values, then mag_raw selected by mode.
  - mag = min(mag_raw, 2^PIX_W-1).
  - gx and gy are passed through registered.
- Latency: exactly 3 cycles from input transfer to out_valid when unstalled. Throughput is 1 window per cycle.
- Outputs hold stable while out_valid && !out_ready.
- in_valid=0 inserts a bubble. A bubble stage keeps its data flops unchanged (valid bit cleared).

Optional Feature:
Macro: SOBEL_THRESH_EN.
- Defined:
  - Adds input port thresh [PIX_W-1:0] and output edge.
  - thresh is sampled with the window and piped alongside it.
  - edge = (mag >= thresh) at stage 3, with the same timing and stall behaviour as mag. Reset value 0.
- Undefined:
  - Ports thresh and edge are absent.
  - No comparator logic is present.

Decomposition:
- Shared package sobel_pkg:
  - mode_t enum: MODE_VERT=2'b00, MODE_HORZ=2'b01, MODE_BOTH=2'b10; 2'b11 decodes as MODE_BOTH.
  - Function for the GRAD_W computation.
  - Saturation helper function.
- Sub-module sobel_kernel3: combinational signed 1-2-1 weighted sum of three differences. Instantiated twice, for gx and gy.
- Pipeline registers and handshake stay in the top module.

Test Plan:
1. Reset, then a top row of 255 and all other pixels 0, mode=00, out_ready=1 -> after 3 cycles: gy=+1020, gx=0, mag=255, out_valid=1 for one cycle.
2. Left column 0 and right column 200 (P2,P5,P8=200, rest 0), mode=01 -> gx=+800, gy=0, mag=255. Same window with mode=00 -> mag=0.
3. Window P0=10, P2=14, rest 0, mode=10 -> gy=24, gx=4, mag=28. Repeat with mode=11 -> identical result.
4. Stream 6 back-to-back windows, then drop out_ready for 4 cycles mid-stream:
   - in_ready=0 during the stall.
   - gx/gy/mag stable while stalled.
   - All 6 results arrive in order with none lost or duplicated.
5. Three windows in flight, then n_rst=0 for one cycle -> next edge out_valid=0, outputs 0. No stale result appears afterwards.
6. With SOBEL_THRESH_EN: thresh=100 and windows giving mag 99, 100, 255 -> edge = 0, 1, 1 respectively, aligned with mag.
